// File: rtl/led_counter_pkg.sv
// led_counter_pkg
// Shared definitions for the LED counter family.
//   mode_t : encoding of the 2-bit mode input (up, down, hold, bounce)
//   dir_t  : bounce direction state (up / down)
package led_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_sync_edge.sv
// tick_sync_edge
// Synchronises a slow asynchronous level into fpga_clk and emits a one-cycle
// pulse on each of its rising edges.
//   fpga_clk      in  system clock
//   sys_init_ctrl in  synchronous active-high reset
//   async_in      in  asynchronous slow input
//   tick          out one-cycle pulse per rising edge of async_in
// Every flop resets to 1, so an input already high at reset release is
// treated as "already seen" and produces no pulse until it goes low and
// then high again.
module tick_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic fpga_clk,
    input  logic sys_init_ctrl,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_prev_reg;
    logic                   s_last;

    assign s_last = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            sync_reg   <= '1;
            s_prev_reg <= 1'b1;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], async_in};
            s_prev_reg <= s_last;
        end
    end

    assign tick = s_last & ~s_prev_reg;

endmodule

// File: rtl/led_counter_param.sv
// led_counter_param
// Parametrised LED counter clocked by fpga_clk; the slow tick is treated as a
// count enable after synchronisation and edge detection.
//   fpga_clk      in  system clock
//   sys_init_ctrl in  synchronous active-high reset
//   tick_in       in  slow asynchronous tick, counted on its rising edge
//   mode          in  00 up, 01 down, 10 hold, 11 bounce
//   load          in  synchronous load strobe (beats a coincident tick)
//   load_val      in  load value, clamped to MAX
//   led           out current count
//   term_pulse    out one-cycle pulse after a tick that found led at the limit
module led_counter_param
    import led_counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX         = {WIDTH{1'b1}},
    parameter bit               SATURATE    = 1'b0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             fpga_clk,
    input  logic             sys_init_ctrl,
    input  logic             tick_in,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             term_pulse
);

    logic             tick;
    logic [WIDTH-1:0] led_reg;
    logic [WIDTH-1:0] led_next;
    dir_t             dir_reg;
    dir_t             dir_next;
    logic             term_reg;
    logic             term_next;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] one_val;
    mode_t            mode_sel;

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync_edge (
        .fpga_clk     (fpga_clk),
        .sys_init_ctrl(sys_init_ctrl),
        .async_in     (tick_in),
        .tick         (tick)
    );

    assign at_max   = (led_reg == MAX);
    assign at_zero  = (led_reg == '0);
    assign mode_sel = mode_t'(mode);

    // Constant 1 at WIDTH bits, valid even for WIDTH == 1.
    always_comb begin
        one_val    = '0;
        one_val[0] = 1'b1;
    end

    always_comb begin
        led_next  = led_reg;
        dir_next  = dir_reg;
        term_next = 1'b0;
        if (load) begin
            // Load wins over a same-cycle tick; direction is left alone.
            led_next = (load_val > MAX) ? MAX : load_val;
        end else if (tick) begin
            case (mode_sel)
                MODE_UP: begin
                    if (at_max) begin
                        term_next = 1'b1;
                        led_next  = SATURATE ? MAX : '0;
                    end else begin
                        led_next = led_reg + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        term_next = 1'b1;
                        led_next  = SATURATE ? '0 : MAX;
                    end else begin
                        led_next = led_reg - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // Reversal steps away from the limit on the same tick,
                    // so the limit value is shown for exactly one tick.
                    if (dir_reg == DIR_UP) begin
                        if (at_max) begin
                            term_next = 1'b1;
                            led_next  = MAX - 1'b1;
                            dir_next  = DIR_DOWN;
                        end else begin
                            led_next = led_reg + 1'b1;
                        end
                    end else begin
                        if (at_zero) begin
                            term_next = 1'b1;
                            led_next  = one_val;
                            dir_next  = DIR_UP;
                        end else begin
                            led_next = led_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    // Hold: tick ignored.
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            led_reg  <= '0;
            dir_reg  <= DIR_UP;
            term_reg <= 1'b0;
        end else begin
            led_reg  <= led_next;
            dir_reg  <= dir_next;
            term_reg <= term_next;
        end
    end

    assign led        = led_reg;
    assign term_pulse = term_reg;

endmodule

// File: tb/tb_led_counter_param.sv
// tb_led_counter_param
// Four counter instances share clock, reset and tick_in:
//   d0: WIDTH=8 default MAX, wrap      d1: WIDTH=4 MAX=9 saturate
//   d2: WIDTH=3 MAX=5 (bounce)         d3: WIDTH=8 MAX=150 (load clamp)
// Expected led/term_pulse values are pushed to a queue when a tick is driven
// and popped on the update edge.
module tb_led_counter_param;

    logic       fpga_clk = 1'b0;
    logic       sys_init_ctrl;
    logic       tick_in;
    logic [1:0] mode_s [4];
    logic [3:0] load_vec;
    logic [7:0] load_val_s;
    logic [7:0] led0;
    logic [3:0] led1;
    logic [2:0] led2;
    logic [7:0] led3;
    logic [3:0] term_vec;

    always #5 fpga_clk = ~fpga_clk;

    led_counter_param #(.WIDTH(8)) d0 (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .tick_in(tick_in),
        .mode(mode_s[0]), .load(load_vec[0]), .load_val(load_val_s),
        .led(led0), .term_pulse(term_vec[0]));
    led_counter_param #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) d1 (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .tick_in(tick_in),
        .mode(mode_s[1]), .load(load_vec[1]), .load_val(load_val_s[3:0]),
        .led(led1), .term_pulse(term_vec[1]));
    led_counter_param #(.WIDTH(3), .MAX(3'd5)) d2 (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .tick_in(tick_in),
        .mode(mode_s[2]), .load(load_vec[2]), .load_val(load_val_s[2:0]),
        .led(led2), .term_pulse(term_vec[2]));
    led_counter_param #(.WIDTH(8), .MAX(8'd150)) d3 (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .tick_in(tick_in),
        .mode(mode_s[3]), .load(load_vec[3]), .load_val(load_val_s),
        .led(led3), .term_pulse(term_vec[3]));

    typedef struct {
        int dut;
        int led;
        bit term;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mx_tab[4]   = '{255, 9, 5, 150};
    bit   sat_tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    int   mask_tab[4] = '{255, 15, 7, 255};
    int   bounce_tbl[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
    int   down_tbl[5]    = '{2, 1, 0, 0, 0};
    int   model_led[4];
    bit   model_dir[4];   // 0 = up, 1 = down
    int   tick_count;
    int   term_count;
    int   term_tick;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int obs_led(input int i);
        case (i)
            0:       return int'(led0);
            1:       return int'(led1);
            2:       return int'(led2);
            default: return int'(led3);
        endcase
    endfunction

    function automatic int obs_term(input int i);
        return int'(term_vec[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            model_led[i] = 0;
            model_dir[i] = 1'b0;
        end
    endtask

    // Behaviour of one accepted tick, straight from the mode descriptions.
    task automatic model_step(input int i, output bit term);
        int mx;
        mx   = mx_tab[i];
        term = 1'b0;
        case (mode_s[i])
            2'b00: begin
                if (model_led[i] == mx) begin
                    term = 1'b1;
                    model_led[i] = sat_tab[i] ? mx : 0;
                end else model_led[i]++;
            end
            2'b01: begin
                if (model_led[i] == 0) begin
                    term = 1'b1;
                    model_led[i] = sat_tab[i] ? 0 : mx;
                end else model_led[i]--;
            end
            2'b11: begin
                if (!model_dir[i]) begin
                    if (model_led[i] == mx) begin
                        term = 1'b1; model_led[i] = mx - 1; model_dir[i] = 1'b1;
                    end else model_led[i]++;
                end else begin
                    if (model_led[i] == 0) begin
                        term = 1'b1; model_led[i] = 1; model_dir[i] = 1'b0;
                    end else model_led[i]--;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_load(input int i);
        int v;
        v = int'(load_val_s) & mask_tab[i];
        model_led[i] = (v > mx_tab[i]) ? mx_tab[i] : v;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_led"}, obs_led(i), 0);
            chk({tag, "_term"}, obs_term(i), 0);
        end
    endtask

    // One tick_in pulse; ld_mask loads the selected instances on the very
    // edge that consumes the detected tick.
    task automatic do_tick(input logic [3:0] ld_mask);
        int   prev0;
        bit   t;
        exp_t e;
        prev0 = model_led[0];
        @(negedge fpga_clk);
        tick_in = 1'b1;
        tick_count++;
        for (int i = 0; i < 4; i++) begin
            t = 1'b0;
            if (ld_mask[i]) model_load(i);
            else model_step(i, t);
            sb_q.push_back('{dut: i, led: model_led[i], term: t});
        end
        @(posedge fpga_clk); #1;              // edge 1
        @(posedge fpga_clk); #1;              // edge 2
        chk("latency", obs_led(0), prev0);
        @(negedge fpga_clk);
        load_vec = ld_mask;
        @(posedge fpga_clk); #1;              // edge 3: update
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("led%0d", e.dut), obs_led(e.dut), e.led);
            chk($sformatf("term%0d", e.dut), obs_term(e.dut), int'(e.term));
            if (e.dut == 0 && obs_term(0) == 1) begin
                term_count++;
                term_tick = tick_count;
            end
        end
        @(negedge fpga_clk);
        load_vec = 4'b0000;
        @(posedge fpga_clk); #1;              // edge 4: pulse over
        for (int i = 0; i < 4; i++) chk("term_clr", obs_term(i), 0);
        @(negedge fpga_clk);
        tick_in = 1'b0;
        repeat (4) @(negedge fpga_clk);
    endtask

    task automatic do_load(input logic [3:0] ld_mask, input logic [7:0] val);
        @(negedge fpga_clk);
        load_vec   = ld_mask;
        load_val_s = val;
        for (int i = 0; i < 4; i++) if (ld_mask[i]) model_load(i);
        @(posedge fpga_clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (ld_mask[i]) begin
                chk("load_led", obs_led(i), model_led[i]);
                chk("load_term", obs_term(i), 0);
            end
        end
        @(negedge fpga_clk);
        load_vec = 4'b0000;
    endtask

    initial begin
        sys_init_ctrl = 1'b1;
        tick_in       = 1'b0;
        load_vec      = 4'b0000;
        load_val_s    = 8'd0;
        for (int i = 0; i < 4; i++) mode_s[i] = 2'b00;
        repeat (4) @(negedge fpga_clk);
        sys_init_ctrl = 1'b0;
        model_reset();
        @(posedge fpga_clk); #1;
        check_all_zero("reset");

        // d0 up/wrap, d1 down/saturate from 3, d2 bounce, d3 hold then up.
        mode_s[0] = 2'b00;
        mode_s[1] = 2'b01;
        mode_s[2] = 2'b11;
        mode_s[3] = 2'b10;
        do_load(4'b0010, 8'd3);
        tick_count = 0;
        term_count = 0;
        term_tick  = 0;
        for (int k = 1; k <= 257; k++) begin
            if (k == 11) begin
                chk("hold_led", obs_led(3), 0);
                mode_s[3] = 2'b00;
            end
            do_tick(4'b0000);
            if (k <= 12) chk("bounce_tbl", obs_led(2), bounce_tbl[k-1]);
            if (k <= 5)  chk("down_tbl", obs_led(1), down_tbl[k-1]);
        end
        chk("term_once", term_count, 1);
        chk("term_at", term_tick, 256);

        // Load above MAX coincident with a tick: clamp, no count.
        load_val_s = 8'd200;
        do_tick(4'b1000);
        chk("clamp", obs_led(3), 150);
        do_tick(4'b0000);
        chk("clamp_wrap", obs_led(3), 0);

        // tick_in held high through reset release must not count.
        @(negedge fpga_clk);
        tick_in       = 1'b1;
        sys_init_ctrl = 1'b1;
        repeat (3) @(negedge fpga_clk);
        sys_init_ctrl = 1'b0;
        model_reset();
        repeat (6) @(negedge fpga_clk);
        #1;
        check_all_zero("high_rst");
        tick_in = 1'b0;
        repeat (4) @(negedge fpga_clk);
        do_tick(4'b0000);
        chk("first_cnt", obs_led(0), 1);

        // Reset one cycle before the detected tick: the tick is lost.
        @(negedge fpga_clk);
        tick_in = 1'b1;
        @(negedge fpga_clk);
        sys_init_ctrl = 1'b1;
        @(negedge fpga_clk);
        sys_init_ctrl = 1'b0;
        model_reset();
        repeat (5) @(negedge fpga_clk);
        #1;
        check_all_zero("rst_tick");
        tick_in = 1'b0;
        repeat (4) @(negedge fpga_clk);

        // One-cycle glitch: at most one count.
        @(negedge fpga_clk);
        tick_in = 1'b1;
        @(negedge fpga_clk);
        tick_in = 1'b0;
        repeat (6) @(negedge fpga_clk);
        #1;
        chk("glitch", (obs_led(0) <= model_led[0] + 1) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
